// File: rtl/mult_seq.sv
// Sequential 32x32 multiplier: radix-4 shift-add over 16 cycles on operand
// magnitudes, with the sign applied to the 64-bit result at the end.
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | waiting for valid; hi/lo hold the last result
// S_BUSY | one radix-4 iteration per edge, 16 edges in total
// S_DONE | hi/lo just loaded; done pulses for this single cycle
module mult_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        last_iter;

    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        neg;
    logic [63:0] acc;
    logic [3:0]  count;

    logic [33:0] pp_digit;
    logic [63:0] pp;
    logic [63:0] acc_sum;
    logic [63:0] result;

    assign last_iter = (count == 4'd15);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    accept    = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // flush wins over everything, including a same-edge accept
        if (flush) begin
            state_nxt = S_IDLE;
            accept    = 1'b0;
        end
    end

    always_comb begin
        pp_digit = 34'd0;
        case (mplier[1:0])
            2'd0: pp_digit = 34'd0;
            2'd1: pp_digit = {2'b00, mcand};
            2'd2: pp_digit = {1'b0, mcand, 1'b0};
            2'd3: pp_digit = {2'b00, mcand} + {1'b0, mcand, 1'b0};
            default: pp_digit = 34'd0;
        endcase
    end

    assign pp      = {30'd0, pp_digit} << {count, 1'b0};
    assign acc_sum = acc + pp;
    assign result  = neg ? (~acc_sum + 64'd1) : acc_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            neg    <= 1'b0;
            acc    <= 64'd0;
            count  <= 4'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // 0x80000000 negates to itself, which is the correct unsigned magnitude
                mcand  <= (is_signed && a[31]) ? (~a + 32'd1) : a;
                mplier <= (is_signed && b[31]) ? (~b + 32'd1) : b;
                neg    <= is_signed & (a[31] ^ b[31]);
                acc    <= 64'd0;
                count  <= 4'd0;
            end else if (state == S_BUSY && !flush) begin
                acc    <= acc_sum;
                mplier <= {2'b00, mplier[31:2]};
                count  <= count + 4'd1;
                if (last_iter) begin
                    hi <= result[63:32];
                    lo <= result[31:0];
                end
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed vectors push expected products into a queue,
// a monitor pops and checks them (value and latency) on every done pulse.
module tb_mult_seq;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    mult_seq dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .flush     (flush),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [63:0] prod;
        int          acc_edge;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    int   done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // monitor: samples 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        edge_cnt++;
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk({e.name, "_product"}, {hi, lo}, e.prod);
                chk({e.name, "_latency"}, 64'(edge_cnt - e.acc_edge), 64'd16);
            end
        end
    end

    // drives one valid cycle; the following rising edge is the accept edge
    task automatic start(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         input logic [63:0] prod, input string name, input bit push);
        exp_t e;
        @(negedge clk);
        valid     = 1'b1;
        a         = av;
        b         = bv;
        is_signed = sv;
        if (push) begin
            e.prod     = prod;
            e.acc_edge = edge_cnt + 1;
            e.name     = name;
            q.push_back(e);
        end
        @(negedge clk);
        valid     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk({name, "_idle_timeout"}, 64'd1, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int busy_cycles;
        int dc;
        resetn    = 1'b0;
        valid     = 1'b0;
        flush     = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        is_signed = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // unsigned full range, plus busy width
        start(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "u_max", 1);
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        chk("u_max_busy_cycles", 64'(busy_cycles), 64'd17);

        start(32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFF_FFFFFFFF, "s_neg1x1", 1);
        wait_idle("s_neg1x1");
        start(32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000_FFFFFFFF, "u_ffx1", 1);
        wait_idle("u_ffx1");
        start(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "s_min_sq", 1);
        wait_idle("s_min_sq");
        start(32'h80000000, 32'h00000002, 1'b1, 64'hFFFFFFFF_00000000, "s_minx2", 1);
        wait_idle("s_minx2");
        start(32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFEB, "s_m3x7", 1);
        wait_idle("s_m3x7");
        start(32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 64'h00000000_00000006, "s_m2xm3", 1);
        wait_idle("s_m2xm3");

        // back-to-back: second start lands on the earliest legal accept edge
        start(32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000, "b2b_first", 1);
        repeat (16) @(negedge clk);
        start(32'h00000003, 32'h00000004, 1'b0, 64'h00000000_0000000C, "b2b_second", 1);
        wait_idle("b2b_second");

        // valid during BUSY is ignored
        dc = done_cnt;
        start(32'd3, 32'd5, 1'b0, 64'd15, "busy_ign", 1);
        repeat (3) @(negedge clk);
        valid = 1'b1; a = 32'd7; b = 32'd7;
        @(negedge clk);
        valid = 1'b0;
        wait_idle("busy_ign");
        repeat (20) @(negedge clk);
        chk("busy_ign_done_count", 64'(done_cnt - dc), 64'd1);

        // flush mid-operation
        dc = done_cnt;
        start(32'd9, 32'd9, 1'b0, 64'd0, "flush", 0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hold", {hi, lo}, 64'd15);
        repeat (20) @(negedge clk);
        chk("flush_no_done", 64'(done_cnt - dc), 64'd0);

        // flush and valid together in IDLE
        valid = 1'b1; flush = 1'b1; a = 32'd4; b = 32'd4;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        chk("flush_valid_no_accept", {63'd0, busy}, 64'd0);

        // asynchronous reset mid-operation
        dc = done_cnt;
        start(32'h00001234, 32'h00005678, 1'b0, 64'd0, "rst_mid", 0);
        repeat (7) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_outputs", {hi, lo}, 64'd0);
        chk("rst_mid_busy_done", {62'd0, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (25) @(negedge clk);
        chk("rst_mid_no_done", 64'(done_cnt - dc), 64'd0);

        start(32'd2, 32'd3, 1'b0, 64'd6, "post_rst", 1);
        wait_idle("post_rst");
        repeat (3) @(negedge clk);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameters: none; the operand width is fixed at 32 bits and the product at 64 bits.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 valid  in  1  start request, sampled on the rising edge.
REQ-005 a  in  32  multiplicand, sampled on the accept edge.
REQ-006 b  in  32  multiplier, sampled on the accept edge.
REQ-007 is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled on the accept edge.
REQ-008 flush  in  1  synchronous abort of any operation in progress.
REQ-009 hi  out  32  upper 32 bits of the 64-bit product.
REQ-010 lo  out  32  lower 32 bits of the 64-bit product.
REQ-011 busy  out  1  high whenever state != IDLE.
REQ-012 done  out  1  one-cycle pulse marking hi/lo valid for the latest operation.

Function
REQ-013 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-014 Accept edge = rising edge with state IDLE, valid=1 and flush=0.
- Latch |a| and |b|; a magnitude is negated only if is_signed=1 and that operand's bit 31 = 1.
- Latch neg = is_signed & (a[31]^b[31]).
- Clear the 64-bit accumulator and the 4-bit iteration counter; go to BUSY.
REQ-015 Each BUSY edge SHALL perform one radix-4 shift-add iteration.
- Consume the next 2 LSBs of the multiplier magnitude.
- Add mcand*{0,1,2,3} << (2*count) into the 64-bit accumulator, then increment count.
REQ-016 After the 16th BUSY iteration (count wraps 15->0), the same edge SHALL:
- load {hi,lo} = neg ? -acc : acc (64-bit two's-complement negate);
- move to DONE.
REQ-017 In DONE, done=1 for exactly one cycle; the next edge returns to IDLE.
REQ-018 Latency: done SHALL be high in the cycle following the 16th edge after the accept edge, and for that cycle only.
REQ-019 hi/lo SHALL hold their value until the next DONE load; they do not change during BUSY.
REQ-020 valid in BUSY or DONE SHALL be ignored (no queuing), and a, b and is_signed SHALL be don't-care outside the accept edge.
REQ-021 flush=1 on any edge SHALL force IDLE without a DONE load.
- hi/lo keep their previous values; done is not asserted.
- flush has priority over valid on the same edge, so no accept occurs.
REQ-022 The earliest next accept is the edge after the DONE cycle, i.e. 18 edges after the previous accept.
REQ-023 Results SHALL be exact for all operands, including signed 0x80000000 (magnitude 2^31, handled as unsigned 32-bit).

Reset
REQ-024 resetn=0 SHALL, asynchronously and regardless of clk:
- force state=IDLE, hi=0, lo=0, done=0, busy=0;
- clear the accumulator, counter and latched operands.
REQ-025 Reset asserted mid-operation SHALL discard that operation; no done pulse follows the release.
REQ-026 The first accept after reset release SHALL behave identically to any other accept.

Verification
REQ-027 Unsigned full range: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001, with done high exactly 16 edges after the accept edge and busy high for 17 cycles.
REQ-028 Signed mixed sign: a=0xFFFFFFFF (-1), b=0x00000001, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. Same operands with is_signed=0 -> hi=0x00000000, lo=0xFFFFFFFF.
REQ-029 Signed extreme: a=0x80000000, b=0x80000000, is_signed=1 -> hi=0x40000000, lo=0x00000000. Separately, a=0x80000000, b=0x00000002 -> hi=0xFFFFFFFF, lo=0x00000000.
REQ-030 Busy-ignore and flush:
- Start 3x5, then pulse valid with 7x7 while BUSY -> one done only, hi=0, lo=15.
- Start 9x9 and flush after 5 edges -> no done, hi/lo still 0/15, busy=0 on the next cycle.
- flush and valid together in IDLE -> no accept.
REQ-031 Reset mid-operation:
- Start 0x1234x0x5678 and drop resetn asynchronously between edges at cycle 8 -> hi/lo/done/busy go to 0 immediately, and no done follows the release.
- Then 2x3 -> lo=6, hi=0.
